// File: rtl/rb_bridge_pkg.sv
// Shared definitions for the byte-stream to register-bus bridge.
package rb_bridge_pkg;

    // Command byte layout: bit 7 selects write (1) or read (0),
    // bits 6:0 hold the burst length minus one.
    localparam int CMD_W_BIT   = 7;
    localparam int CMD_LEN_MSB = 6;

    // Largest burst a single command can request.
    localparam int MAX_BURST   = 128;

    // Width of the remaining-bytes down-counter (holds N-1).
    localparam int CNT_BITS    = $clog2(MAX_BURST);

    // Bridge FSM states. IDLE must encode as zero so that reset and
    // the all-zero register image agree.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_WR_STB  = 3'd3,
        ST_RD_REQ  = 3'd4,
        ST_RD_WAIT = 3'd5,
        ST_RD_SEND = 3'd6
    } state_t;

    // True in the states that take bytes from the host link.
    function automatic logic state_accepts_rx(input state_t s);
        return (s == ST_IDLE) || (s == ST_ADDR) || (s == ST_WR_DATA);
    endfunction

    // True in the states that drive the register access strobe.
    function automatic logic state_drives_reg_en(input state_t s);
        return (s == ST_WR_STB) || (s == ST_RD_REQ);
    endfunction

endpackage

// File: rtl/rb_cmd_bridge.sv
// Byte-stream command bridge: decodes CMD/ADDR/data frames from the host
// link into register-bus reads and writes, and streams read data back.
// Every output is a flop; output next-values are derived from the next
// state so each output lines up exactly with the state it belongs to.
module rb_cmd_bridge
    import rb_bridge_pkg::*;
#(
    parameter int ADR_BITS = 8
) (
    input  logic                clk,
    input  logic                resetb,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    input  logic                frame_abort,
    output logic [ADR_BITS-1:0] rb_address,
    output logic [7:0]          rb_data_write,
    input  logic [7:0]          rb_data_read,
    output logic                rb_reg_en,
    output logic                rb_write_en,
    output logic                busy
);

    state_t                state_q,         state_d;
    logic                  is_write_q,      is_write_d;
    logic [CNT_BITS-1:0]   count_q,         count_d;
    logic [ADR_BITS-1:0]   rb_address_q,    rb_address_d;
    logic [7:0]            rb_data_write_q, rb_data_write_d;
    logic [7:0]            tx_data_q,       tx_data_d;
    logic                  tx_valid_q,      tx_valid_d;
    logic                  rx_ready_q,      rx_ready_d;
    logic                  rb_reg_en_q,     rb_reg_en_d;
    logic                  rb_write_en_q,   rb_write_en_d;
    logic                  busy_q,          busy_d;

    logic                  rx_fire;
    logic                  tx_fire;
    logic                  last_byte;

    // Handshakes use the registered ready/valid that the peers actually see.
    assign rx_fire   = rx_valid & rx_ready_q;
    assign tx_fire   = tx_valid_q & tx_ready;
    assign last_byte = (count_q == '0);

    // Next-state, datapath and registered-output next values.
    always_comb begin
        state_d         = state_q;
        is_write_d      = is_write_q;
        count_d         = count_q;
        rb_address_d    = rb_address_q;
        rb_data_write_d = rb_data_write_q;
        tx_data_d       = tx_data_q;

        case (state_q)
            ST_IDLE: begin
                if (rx_fire) begin
                    is_write_d = rx_data[CMD_W_BIT];
                    count_d    = rx_data[CMD_LEN_MSB:0];
                    state_d    = ST_ADDR;
                end
            end

            ST_ADDR: begin
                if (rx_fire) begin
                    rb_address_d = ADR_BITS'(rx_data);
                    state_d      = is_write_q ? ST_WR_DATA : ST_RD_REQ;
                end
            end

            ST_WR_DATA: begin
                if (rx_fire) begin
                    rb_data_write_d = rx_data;
                    state_d         = ST_WR_STB;
                end
            end

            // The strobe is on the bus this cycle; advance to the next byte.
            ST_WR_STB: begin
                rb_address_d = rb_address_q + ADR_BITS'(1);
                count_d      = count_q - CNT_BITS'(1);
                state_d      = last_byte ? ST_IDLE : ST_WR_DATA;
            end

            // Bank samples the address at the end of this cycle.
            ST_RD_REQ: begin
                state_d = ST_RD_WAIT;
            end

            // Bank read data is valid now; capture it for the tx side.
            ST_RD_WAIT: begin
                tx_data_d = rb_data_read;
                state_d   = ST_RD_SEND;
            end

            // Hold the byte until the consumer takes it; only then issue
            // the next read so no second read is ever outstanding.
            ST_RD_SEND: begin
                if (tx_fire) begin
                    rb_address_d = rb_address_q + ADR_BITS'(1);
                    count_d      = count_q - CNT_BITS'(1);
                    state_d      = last_byte ? ST_IDLE : ST_RD_REQ;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides every transition: anything latched this cycle is
        // discarded. A write strobe already on the bus is not recalled.
        if (frame_abort) begin
            state_d         = ST_IDLE;
            is_write_d      = is_write_q;
            count_d         = count_q;
            rb_address_d    = rb_address_q;
            rb_data_write_d = rb_data_write_q;
            tx_data_d       = tx_data_q;
        end

        rx_ready_d    = state_accepts_rx(state_d);
        rb_reg_en_d   = state_drives_reg_en(state_d);
        rb_write_en_d = (state_d == ST_WR_STB);
        tx_valid_d    = (state_d == ST_RD_SEND);
        busy_d        = (state_d != ST_IDLE);
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            state_q         <= ST_IDLE;
            is_write_q      <= 1'b0;
            count_q         <= '0;
            rb_address_q    <= '0;
            rb_data_write_q <= '0;
            tx_data_q       <= '0;
            tx_valid_q      <= 1'b0;
            rx_ready_q      <= 1'b0;
            rb_reg_en_q     <= 1'b0;
            rb_write_en_q   <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            is_write_q      <= is_write_d;
            count_q         <= count_d;
            rb_address_q    <= rb_address_d;
            rb_data_write_q <= rb_data_write_d;
            tx_data_q       <= tx_data_d;
            tx_valid_q      <= tx_valid_d;
            rx_ready_q      <= rx_ready_d;
            rb_reg_en_q     <= rb_reg_en_d;
            rb_write_en_q   <= rb_write_en_d;
            busy_q          <= busy_d;
        end
    end

    assign rx_ready      = rx_ready_q;
    assign tx_data       = tx_data_q;
    assign tx_valid      = tx_valid_q;
    assign rb_address    = rb_address_q;
    assign rb_data_write = rb_data_write_q;
    assign rb_reg_en     = rb_reg_en_q;
    assign rb_write_en   = rb_write_en_q;
    assign busy          = busy_q;

endmodule
